// File: rtl/pc_sequencer.sv
// Fetch/retire controller for the program-counter register: sequences PC loads,
// runs the instruction-memory fetch handshake and holds the instruction until retire.
module pc_sequencer #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter logic [31:0] EXC_VECTOR = 32'h0000_0004
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] pc_cur,
   output logic        pc_ena,
   output logic [31:0] pc_data,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] ir,
   output logic        ir_valid,
   input  logic        ex_done,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   input  logic        jump_valid,
   input  logic [31:0] jump_target,
   input  logic        exc_req,
   input  logic        halt_req,
   output logic        exc_taken,
   output logic [31:0] epc,
   output logic [1:0]  cause,
   output logic [31:0] instr_count,
   output logic        halted
);

   typedef enum logic [1:0] {
      ST_BOOT  = 2'd0,
      ST_FETCH = 2'd1,
      ST_EXEC  = 2'd2,
      ST_HALT  = 2'd3
   } state_t;

   localparam logic [1:0] CAUSE_EXT = 2'b01;
   localparam logic [1:0] CAUSE_MIS = 2'b10;

   state_t      state_q, state_d;
   logic [31:0] ir_q, ir_d;
   logic [31:0] epc_q, epc_d;
   logic [1:0]  cause_q, cause_d;
   logic [31:0] instr_count_q, instr_count_d;
   logic        halted_q, halted_d;

   logic [31:0] sel_target;
   logic        redirect;
   logic        misaligned;
   logic [31:0] pc_plus4;

   // Jump outranks branch, so its target is the one checked for alignment.
   assign sel_target = jump_valid ? jump_target : branch_target;
   assign redirect   = jump_valid | branch_taken;
   assign misaligned = redirect & (sel_target[1:0] != 2'b00);
   assign pc_plus4   = pc_cur + 32'd4;

   always_comb begin
      state_d       = state_q;
      ir_d          = ir_q;
      epc_d         = epc_q;
      cause_d       = cause_q;
      instr_count_d = instr_count_q;
      halted_d      = halted_q;
      pc_ena        = 1'b0;
      pc_data       = pc_plus4;
      imem_req      = 1'b0;
      exc_taken     = 1'b0;

      case (state_q)
         ST_BOOT: begin
            pc_ena  = 1'b1;
            pc_data = RESET_PC;
            state_d = ST_FETCH;
         end
         ST_FETCH: begin
            imem_req = 1'b1;
            if (imem_ack) begin
               ir_d    = imem_rdata;
               state_d = ST_EXEC;
            end
         end
         ST_EXEC: begin
            if (ex_done) begin
               pc_ena        = 1'b1;
               instr_count_d = instr_count_q + 32'd1;
               if (exc_req || misaligned) begin
                  pc_data   = EXC_VECTOR;
                  exc_taken = 1'b1;
                  epc_d     = pc_cur;
                  cause_d   = exc_req ? CAUSE_EXT : CAUSE_MIS;
               end else if (redirect) begin
                  pc_data = sel_target;
               end
               if (halt_req) begin
                  state_d  = ST_HALT;
                  halted_d = 1'b1;
               end else begin
                  state_d = ST_FETCH;
               end
            end
         end
         ST_HALT: begin
            state_d = ST_HALT;
         end
         default: state_d = ST_BOOT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q       <= ST_BOOT;
         ir_q          <= '0;
         epc_q         <= '0;
         cause_q       <= '0;
         instr_count_q <= '0;
         halted_q      <= 1'b0;
      end else begin
         state_q       <= state_d;
         ir_q          <= ir_d;
         epc_q         <= epc_d;
         cause_q       <= cause_d;
         instr_count_q <= instr_count_d;
         halted_q      <= halted_d;
      end
   end

   assign imem_addr   = pc_cur;
   assign ir          = ir_q;
   assign ir_valid    = (state_q == ST_EXEC);
   assign epc         = epc_q;
   assign cause       = cause_q;
   assign instr_count = instr_count_q;
   assign halted      = halted_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer; models the external PC register and checks
// hand-computed values at each step.
module tb_pc_sequencer;

   logic        clk;
   logic        rst;
   logic [31:0] pc_cur;
   logic        pc_ena;
   logic [31:0] pc_data;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic [31:0] ir;
   logic        ir_valid;
   logic        ex_done;
   logic        branch_taken;
   logic [31:0] branch_target;
   logic        jump_valid;
   logic [31:0] jump_target;
   logic        exc_req;
   logic        halt_req;
   logic        exc_taken;
   logic [31:0] epc;
   logic [1:0]  cause;
   logic [31:0] instr_count;
   logic        halted;

   int vectors;
   int miscompares;

   pc_sequencer #(
      .RESET_PC  (32'h0000_0000),
      .EXC_VECTOR(32'h0000_0004)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .pc_cur       (pc_cur),
      .pc_ena       (pc_ena),
      .pc_data      (pc_data),
      .imem_req     (imem_req),
      .imem_addr    (imem_addr),
      .imem_ack     (imem_ack),
      .imem_rdata   (imem_rdata),
      .ir           (ir),
      .ir_valid     (ir_valid),
      .ex_done      (ex_done),
      .branch_taken (branch_taken),
      .branch_target(branch_target),
      .jump_valid   (jump_valid),
      .jump_target  (jump_target),
      .exc_req      (exc_req),
      .halt_req     (halt_req),
      .exc_taken    (exc_taken),
      .epc          (epc),
      .cause        (cause),
      .instr_count  (instr_count),
      .halted       (halted)
   );

   // Clock and the PC register the sequencer drives.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial pc_cur = 32'hDEAD_BEEF;
   always @(posedge clk) if (pc_ena === 1'b1) pc_cur <= pc_data;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Advance one edge, then settle a little before the next stimulus.
   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic settle();
      #1;
   endtask

   // One plain instruction: same-cycle ack in FETCH, same-cycle ex_done in EXEC.
   task automatic run_seq(input logic [31:0] addr, input logic [31:0] word,
                          input logic [31:0] exp_next, input string tag);
      imem_ack = 1'b1; imem_rdata = word; settle();
      chk({tag, "_addr"}, imem_addr, addr);
      chk({tag, "_req"}, {31'd0, imem_req}, 32'd1);
      step();
      imem_ack = 1'b0;
      chk({tag, "_ir"}, ir, word);
      chk({tag, "_irv"}, {31'd0, ir_valid}, 32'd1);
      ex_done = 1'b1; settle();
      chk({tag, "_pcena"}, {31'd0, pc_ena}, 32'd1);
      chk({tag, "_pcdata"}, pc_data, exp_next);
      step();
      ex_done = 1'b0;
   endtask

   initial begin
      vectors = 0; miscompares = 0;
      rst = 1'b0; imem_ack = 1'b0; imem_rdata = '0; ex_done = 1'b0;
      branch_taken = 1'b0; branch_target = '0; jump_valid = 1'b0; jump_target = '0;
      exc_req = 1'b0; halt_req = 1'b0;

      // Reset held for three edges.
      step(); step(); step();
      chk("rst_req", {31'd0, imem_req}, 32'd0);
      chk("rst_ir", ir, 32'd0);
      chk("rst_irv", {31'd0, ir_valid}, 32'd0);
      chk("rst_epc", epc, 32'd0);
      chk("rst_cause", {30'd0, cause}, 32'd0);
      chk("rst_cnt", instr_count, 32'd0);
      chk("rst_halted", {31'd0, halted}, 32'd0);
      chk("rst_exc", {31'd0, exc_taken}, 32'd0);
      chk("rst_pcena", {31'd0, pc_ena}, 32'd1);
      chk("rst_pcdata", pc_data, 32'd0);

      // Release: one BOOT cycle, then FETCH at 0.
      rst = 1'b1; settle();
      chk("boot_pcena", {31'd0, pc_ena}, 32'd1);
      step();
      chk("fetch0_req", {31'd0, imem_req}, 32'd1);
      chk("fetch0_addr", imem_addr, 32'd0);
      chk("fetch0_pcena", {31'd0, pc_ena}, 32'd0);

      // Four sequential instructions at CPI 2.
      run_seq(32'h0, 32'hA000_0000, 32'h4, "seq0");
      run_seq(32'h4, 32'hA000_0001, 32'h8, "seq1");
      run_seq(32'h8, 32'hA000_0002, 32'hC, "seq2");
      run_seq(32'hC, 32'hA000_0003, 32'h10, "seq3");
      chk("seq_cnt", instr_count, 32'd4);
      chk("seq_addr", imem_addr, 32'h10);

      // Ack delayed three cycles: request held, ir stable.
      for (int i = 0; i < 3; i++) begin
         settle();
         chk("wait_req", {31'd0, imem_req}, 32'd1);
         chk("wait_ir", ir, 32'hA000_0003);
         chk("wait_irv", {31'd0, ir_valid}, 32'd0);
         step();
      end
      imem_ack = 1'b1; imem_rdata = 32'hB000_0000; step();
      imem_ack = 1'b0;
      chk("late_ir", ir, 32'hB000_0000);
      chk("late_cnt", instr_count, 32'd4);

      // Jump outranks a taken branch.
      jump_valid = 1'b1; jump_target = 32'h100;
      branch_taken = 1'b1; branch_target = 32'h200;
      ex_done = 1'b1; settle();
      chk("jmp_pcdata", pc_data, 32'h100);
      chk("jmp_exc", {31'd0, exc_taken}, 32'd0);
      step();
      ex_done = 1'b0;
      chk("jmp_addr", imem_addr, 32'h100);

      // External exception outranks everything.
      imem_ack = 1'b1; imem_rdata = 32'hC000_0000; step();
      imem_ack = 1'b0;
      exc_req = 1'b1; ex_done = 1'b1; settle();
      chk("exc_pcdata", pc_data, 32'h4);
      chk("exc_pulse", {31'd0, exc_taken}, 32'd1);
      step();
      exc_req = 1'b0; ex_done = 1'b0; jump_valid = 1'b0; branch_taken = 1'b0;
      chk("exc_epc", epc, 32'h100);
      chk("exc_cause", {30'd0, cause}, 32'd1);
      chk("exc_single", {31'd0, exc_taken}, 32'd0);
      chk("exc_addr", imem_addr, 32'h4);
      chk("exc_cnt", instr_count, 32'd6);

      // Misaligned branch target.
      imem_ack = 1'b1; imem_rdata = 32'hD000_0000; step();
      imem_ack = 1'b0;
      branch_taken = 1'b1; branch_target = 32'h102; ex_done = 1'b1; settle();
      chk("mis_pcdata", pc_data, 32'h4);
      chk("mis_exc", {31'd0, exc_taken}, 32'd1);
      step();
      branch_taken = 1'b0; ex_done = 1'b0;
      chk("mis_cause", {30'd0, cause}, 32'd2);
      chk("mis_epc", epc, 32'h4);
      chk("mis_addr", imem_addr, 32'h4);

      // Jump to the top word, then wrap to 0 on sequential retire.
      imem_ack = 1'b1; imem_rdata = 32'hE000_0000; step();
      imem_ack = 1'b0;
      jump_valid = 1'b1; jump_target = 32'hFFFF_FFFC; ex_done = 1'b1; settle();
      chk("top_pcdata", pc_data, 32'hFFFF_FFFC);
      step();
      jump_valid = 1'b0; ex_done = 1'b0;
      chk("top_cause_kept", {30'd0, cause}, 32'd2);
      run_seq(32'hFFFF_FFFC, 32'hE000_0001, 32'h0, "wrap");
      chk("wrap_addr", imem_addr, 32'h0);
      chk("wrap_cnt", instr_count, 32'd9);

      // Halt at the retire of the instruction at 0x8.
      run_seq(32'h0, 32'hF000_0000, 32'h4, "pre0");
      run_seq(32'h4, 32'hF000_0001, 32'h8, "pre1");
      imem_ack = 1'b1; imem_rdata = 32'hF000_0002; step();
      imem_ack = 1'b0;
      halt_req = 1'b1; ex_done = 1'b1; settle();
      chk("halt_pcdata", pc_data, 32'hC);
      step();
      halt_req = 1'b0;
      chk("halt_flag", {31'd0, halted}, 32'd1);
      chk("halt_pc", pc_cur, 32'hC);
      chk("halt_cnt", instr_count, 32'd12);
      for (int i = 0; i < 2; i++) begin
         settle();
         chk("halt_req", {31'd0, imem_req}, 32'd0);
         chk("halt_pcena", {31'd0, pc_ena}, 32'd0);
         chk("halt_irv", {31'd0, ir_valid}, 32'd0);
         step();
      end
      ex_done = 1'b0;
      chk("halt_cnt_hold", instr_count, 32'd12);
      chk("halt_flag_hold", {31'd0, halted}, 32'd1);

      // Reset out of HALT.
      rst = 1'b0; step();
      chk("rh_halted", {31'd0, halted}, 32'd0);
      chk("rh_cnt", instr_count, 32'd0);
      chk("rh_cause", {30'd0, cause}, 32'd0);
      chk("rh_epc", epc, 32'd0);
      chk("rh_ir", ir, 32'd0);
      rst = 1'b1; step();
      chk("rh_fetch_addr", imem_addr, 32'h0);

      // Reset mid-fetch, with an ack arriving during BOOT.
      rst = 1'b0; step();
      rst = 1'b1; imem_ack = 1'b1; imem_rdata = 32'hBAD0_BAD0; settle();
      chk("mf_boot_req", {31'd0, imem_req}, 32'd0);
      step();
      imem_ack = 1'b0; settle();
      chk("mf_ir", ir, 32'd0);
      chk("mf_irv", {31'd0, ir_valid}, 32'd0);
      chk("mf_req", {31'd0, imem_req}, 32'd1);
      chk("mf_addr", imem_addr, 32'h0);
      run_seq(32'h0, 32'h1234_5678, 32'h4, "post");
      chk("post_cnt", instr_count, 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
